// File: rtl/conv_encoder_stream_pkg.sv
// Shared constants, state encoding and code-parameter decoding for the
// streaming convolutional encoder.
package conv_encoder_stream_pkg;

  localparam int MAX_CONSTRAINT_LENGTH = 9;
  localparam int MAX_CODE_RATE         = 3;

  localparam logic RATE_HALF  = 1'b1;
  localparam logic RATE_THIRD = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    TAIL  = 2'd2,
    FLUSH = 2'd3
  } enc_state_e;

  function automatic logic [3:0] constr_to_k(input logic [1:0] code);
    logic [3:0] k;
    case (code)
      2'd1:    k = 4'd3;
      2'd2:    k = 4'd5;
      2'd3:    k = 4'd7;
      default: k = 4'd9;
    endcase
    return k;
  endfunction

  function automatic int active_gens(input logic rate);
    int n;
    n = 3;
    case (rate)
      RATE_HALF:  n = 2;
      RATE_THIRD: n = 3;
      default:    n = 3;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/conv_encoder_stream_parity.sv
// Combinational parity generation: one XOR-reduced tap set per generator,
// restricted to the active constraint length and code rate.
module conv_parity_unit
  import conv_encoder_stream_pkg::*;
#(
  parameter int MAX_K = MAX_CONSTRAINT_LENGTH,
  parameter int MAX_N = MAX_CODE_RATE
) (
  input  logic [MAX_K-1:0]            window,
  input  logic [MAX_N-1:0][MAX_K-1:0] gen_poly,
  input  logic [3:0]                  k_len,
  input  logic                        code_rate,
  output logic [MAX_N-1:0]            parity
);

  logic [MAX_K-1:0] k_mask;

  always_comb begin
    k_mask = '0;
    for (int i = 0; i < MAX_K; i++) begin
      if (i < int'(k_len)) k_mask[i] = 1'b1;
    end
  end

  always_comb begin
    parity = '0;
    for (int j = 0; j < MAX_N; j++) begin
      if (j < active_gens(code_rate)) parity[j] = ^(gen_poly[j] & window & k_mask);
    end
  end

endmodule

// File: rtl/conv_encoder_stream.sv
// Frame-based convolutional encoder with valid/ready on input bits and output
// symbols; every frame is zero-terminated with K-1 tail symbols.
//
// state | meaning
// IDLE  | waiting for first bit of a frame; latches code config on accept
// DATA  | accepting remaining data bits of the frame
// TAIL  | shifting in zeros, one tail symbol per free output slot
// FLUSH | waiting for the last tail symbol to drain, then pulse frame_done
module conv_encoder_stream
  import conv_encoder_stream_pkg::*;
#(
  parameter int MAX_K     = MAX_CONSTRAINT_LENGTH,
  parameter int MAX_N     = MAX_CODE_RATE,
  parameter int FRAME_LEN = 8
) (
  input  logic                        sys_clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        i_code_rate,
  input  logic [1:0]                  i_constr_len,
  input  logic [MAX_N-1:0][MAX_K-1:0] i_gen_poly,
  input  logic                        i_bit,
  input  logic                        i_bit_valid,
  output logic                        o_bit_ready,
  output logic [MAX_N-1:0]            o_code_sym,
  output logic                        o_sym_valid,
  input  logic                        i_sym_ready,
  output logic                        o_tail,
  output logic                        o_frame_done
);

  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN + 1) : 1;
  localparam int TW = $clog2(MAX_K);

  enc_state_e                  state, next_state;
  logic [MAX_K-2:0]            shift_reg;
  logic [BW-1:0]               bit_cnt;
  logic [TW-1:0]               tail_cnt;
  logic                        cfg_rate;
  logic [1:0]                  cfg_len;
  logic [MAX_N-1:0][MAX_K-1:0] cfg_poly;

  logic                        free, pop, accept, tail_step, last_data, last_tail;
  logic                        use_rate, shift_in;
  logic [1:0]                  use_len;
  logic [MAX_N-1:0][MAX_K-1:0] use_poly;
  logic [3:0]                  k_cur;
  logic [MAX_K-1:0]            window;
  logic [MAX_N-1:0]            parity;

  // A held symbol is never consumed while disabled, so free/pop both need en.
  assign free      = en && (!o_sym_valid || i_sym_ready);
  assign pop       = en && o_sym_valid && i_sym_ready;
  assign accept    = i_bit_valid && o_bit_ready;
  assign tail_step = (state == TAIL) && free;

  // The first bit of a frame is encoded with the live config it latches.
  assign use_rate  = (state == IDLE) ? i_code_rate  : cfg_rate;
  assign use_len   = (state == IDLE) ? i_constr_len : cfg_len;
  assign use_poly  = (state == IDLE) ? i_gen_poly   : cfg_poly;
  assign k_cur     = constr_to_k(use_len);
  assign shift_in  = (state == TAIL) ? 1'b0 : i_bit;
  assign window    = {shift_reg, shift_in};
  assign last_data = (state == IDLE) ? (FRAME_LEN == 1) : (bit_cnt == BW'(FRAME_LEN - 1));
  assign last_tail = (tail_cnt == TW'(k_cur - 4'd2));

  conv_parity_unit #(.MAX_K(MAX_K), .MAX_N(MAX_N)) u_parity (
    .window    (window),
    .gen_poly  (use_poly),
    .k_len     (k_cur),
    .code_rate (use_rate),
    .parity    (parity)
  );

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = last_data ? TAIL : DATA;
      DATA:    if (accept && last_data) next_state = TAIL;
      TAIL:    if (tail_step && last_tail) next_state = FLUSH;
      FLUSH:   if (en && !o_sym_valid) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_bit_ready = rst && en && free && ((state == IDLE) || (state == DATA));
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      shift_reg    <= '0;
      bit_cnt      <= '0;
      tail_cnt     <= '0;
      cfg_rate     <= 1'b0;
      cfg_len      <= '0;
      cfg_poly     <= '0;
      o_code_sym   <= '0;
      o_sym_valid  <= 1'b0;
      o_tail       <= 1'b0;
      o_frame_done <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      if (accept || tail_step) begin
        o_code_sym  <= parity;
        o_sym_valid <= 1'b1;
        o_tail      <= (state == TAIL);
        shift_reg   <= window[MAX_K-2:0];
      end else if (pop) begin
        o_sym_valid <= 1'b0;
        o_tail      <= 1'b0;
      end
      if (accept) begin
        if (state == IDLE) begin
          cfg_rate <= i_code_rate;
          cfg_len  <= i_constr_len;
          cfg_poly <= i_gen_poly;
          bit_cnt  <= BW'(1);
        end else begin
          bit_cnt  <= bit_cnt + BW'(1);
        end
      end
      if (tail_step) tail_cnt <= tail_cnt + TW'(1);
      if ((state == FLUSH) && (next_state == IDLE)) begin
        o_frame_done <= 1'b1;
        shift_reg    <= '0;
        bit_cnt      <= '0;
        tail_cnt     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_conv_encoder_stream.sv
// Bench for conv_encoder_stream: three instances (FRAME_LEN 4/1/8) share the
// stimulus, one selected at a time; symbols checked against tables and a tap model.
module tb_conv_encoder_stream;

  logic             sys_clk = 1'b0;
  logic             rst;
  logic             en;
  int               sel;
  logic             i_code_rate;
  logic [1:0]       i_constr_len;
  logic [2:0][8:0]  i_gen_poly;
  logic             i_bit;
  logic             i_bit_valid;
  logic             i_sym_ready;

  logic [2:0] br, sv, tl, fd;
  logic [2:0] sym_o [3];
  logic       obr, osv, otl, ofd;
  logic [2:0] osym;

  int checks = 0;
  int errors = 0;
  int fl [3] = '{4, 1, 8};

  logic [2:0] exp_sym  [$];
  logic       exp_tail [$];

  always #5 sys_clk = ~sys_clk;

  conv_encoder_stream #(.MAX_K(9), .MAX_N(3), .FRAME_LEN(4)) u0 (
    .sys_clk(sys_clk), .rst(rst), .en(en && (sel == 0)), .i_code_rate(i_code_rate),
    .i_constr_len(i_constr_len), .i_gen_poly(i_gen_poly), .i_bit(i_bit),
    .i_bit_valid(i_bit_valid), .o_bit_ready(br[0]), .o_code_sym(sym_o[0]),
    .o_sym_valid(sv[0]), .i_sym_ready(i_sym_ready), .o_tail(tl[0]), .o_frame_done(fd[0]));

  conv_encoder_stream #(.MAX_K(9), .MAX_N(3), .FRAME_LEN(1)) u1 (
    .sys_clk(sys_clk), .rst(rst), .en(en && (sel == 1)), .i_code_rate(i_code_rate),
    .i_constr_len(i_constr_len), .i_gen_poly(i_gen_poly), .i_bit(i_bit),
    .i_bit_valid(i_bit_valid), .o_bit_ready(br[1]), .o_code_sym(sym_o[1]),
    .o_sym_valid(sv[1]), .i_sym_ready(i_sym_ready), .o_tail(tl[1]), .o_frame_done(fd[1]));

  conv_encoder_stream #(.MAX_K(9), .MAX_N(3), .FRAME_LEN(8)) u2 (
    .sys_clk(sys_clk), .rst(rst), .en(en && (sel == 2)), .i_code_rate(i_code_rate),
    .i_constr_len(i_constr_len), .i_gen_poly(i_gen_poly), .i_bit(i_bit),
    .i_bit_valid(i_bit_valid), .o_bit_ready(br[2]), .o_code_sym(sym_o[2]),
    .o_sym_valid(sv[2]), .i_sym_ready(i_sym_ready), .o_tail(tl[2]), .o_frame_done(fd[2]));

  always_comb begin
    obr  = br[sel];
    osv  = sv[sel];
    otl  = tl[sel];
    ofd  = fd[sel];
    osym = sym_o[sel];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic int k_of(input logic [1:0] c);
    case (c)
      2'd1:    return 3;
      2'd2:    return 5;
      2'd3:    return 7;
      default: return 9;
    endcase
  endfunction

  // Reference: each generator output is the parity of the number of set taps
  // over the last K bits of the zero-padded bit sequence.
  task automatic build_expect(input logic rate, input logic [1:0] cl,
                              input logic [2:0][8:0] poly, input logic [7:0] bits,
                              input int nbits);
    int k, ng, total, acc;
    logic seq [$];
    logic [2:0] s;
    k = k_of(cl);
    ng = rate ? 2 : 3;
    total = nbits + k - 1;
    exp_sym.delete();
    exp_tail.delete();
    for (int t = 0; t < nbits; t++) seq.push_back(bits[t]);
    for (int t = 0; t < k - 1; t++) seq.push_back(1'b0);
    for (int t = 0; t < total; t++) begin
      s = 3'b000;
      for (int j = 0; j < ng; j++) begin
        acc = 0;
        for (int i = 0; i < k; i++)
          if ((t - i >= 0) && poly[j][i] && seq[t - i]) acc++;
        s[j] = (acc % 2 == 1);
      end
      exp_sym.push_back(s);
      exp_tail.push_back(t >= nbits);
    end
  endtask

  function automatic logic shreg_zero(input int s);
    case (s)
      0:       return (u0.shift_reg == '0);
      1:       return (u1.shift_reg == '0);
      default: return (u2.shift_reg == '0);
    endcase
  endfunction

  // rdy_mode: 0 always ready, 1 pattern 1-0-0-1, 2 random (with random bit gaps)
  task automatic run_frame(input string tag, input int s, input logic rate,
                           input logic [1:0] cl, input logic [2:0][8:0] poly,
                           input logic [7:0] bits, input int nbits,
                           input int rdy_mode, input int en_drop_at, output int got);
    int sent, last_hs, en_low_left, rdy_ph;
    logic done, dropped, held_valid;
    logic [2:0] held_sym;
    sel = s;
    i_code_rate = rate;
    i_constr_len = cl;
    i_gen_poly = poly;
    sent = 0; got = 0; last_hs = -10; en_low_left = 0; rdy_ph = 0;
    done = 1'b0; dropped = 1'b0; held_valid = 1'b0; held_sym = '0;
    for (int it = 0; it < 400 && !done; it++) begin
      @(negedge sys_clk);
      if (held_valid) chk({tag, " stall_hold"}, {osv, osym}, {1'b1, held_sym});
      if (ofd) begin
        chk({tag, " done_timing"}, it, last_hs + 2);
        chk({tag, " sym_count"}, got, exp_sym.size());
        chk({tag, " shreg_zero"}, shreg_zero(s), 1'b1);
        done = 1'b1;
      end else begin
        if (!dropped && got == en_drop_at) begin
          en_low_left = 3;
          dropped = 1'b1;
        end
        en = (en_low_left == 0);
        if (en_low_left > 0) en_low_left--;
        case (rdy_mode)
          0:       i_sym_ready = 1'b1;
          1:       i_sym_ready = (rdy_ph % 4 == 0) || (rdy_ph % 4 == 3);
          default: i_sym_ready = ($urandom_range(0, 2) != 0);
        endcase
        rdy_ph++;
        i_bit_valid = (sent < nbits) && (rdy_mode != 2 || $urandom_range(0, 3) != 0);
        i_bit = (sent < 8) ? bits[sent] : 1'b0;
        #1;
        if (!en) chk({tag, " ready_en_low"}, obr, 1'b0);
        if (osv && !i_sym_ready) chk({tag, " ready_stall"}, obr, 1'b0);
        if (en && osv && i_sym_ready) begin
          if (got < exp_sym.size()) begin
            chk({tag, " sym"}, osym, exp_sym[got]);
            chk({tag, " tail"}, otl, exp_tail[got]);
          end else begin
            chk({tag, " extra_sym"}, got, exp_sym.size() - 1);
          end
          got++;
          last_hs = it;
          held_valid = 1'b0;
        end else begin
          held_valid = osv;
          held_sym = osym;
        end
        if (i_bit_valid && obr) sent++;
      end
    end
    chk({tag, " done_seen"}, done, 1'b1);
    en = 1'b1;
    i_bit_valid = 1'b0;
    i_sym_ready = 1'b0;
    @(negedge sys_clk);
    chk({tag, " done_pulse"}, ofd, 1'b0);
  endtask

  typedef struct {
    int              sel;
    logic            rate;
    logic [1:0]      cl;
    logic [2:0][8:0] poly;
    logic [7:0]      bits;
    int              nbits;
    int              rdy_mode;
    int              en_drop_at;
    int              nexp;
    logic [7:0][2:0] exp_s;
    logic [7:0]      exp_t;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int got;
    int k9_syms;
    logic [2:0][8:0] p;
    logic [7:0] b;
    logic rate;
    logic [1:0] cl;
    int s;

    vecs[0] = '{0, 1'b1, 2'd1, {9'h000, 9'b101, 9'b111}, 8'b0000_1101, 4, 0, -1, 6,
                {3'd0, 3'd0, 3'b011, 3'b010, 3'b010, 3'b000, 3'b001, 3'b011}, 8'b0011_0000};
    vecs[1] = '{0, 1'b1, 2'd1, {9'h000, 9'b101, 9'b111}, 8'b0000_1101, 4, 1, -1, 6,
                {3'd0, 3'd0, 3'b011, 3'b010, 3'b010, 3'b000, 3'b001, 3'b011}, 8'b0011_0000};
    vecs[2] = '{0, 1'b1, 2'd1, {9'h000, 9'b101, 9'b111}, 8'b0000_1101, 4, 0, 5, 6,
                {3'd0, 3'd0, 3'b011, 3'b010, 3'b010, 3'b000, 3'b001, 3'b011}, 8'b0011_0000};
    vecs[3] = '{1, 1'b0, 2'd1, {9'b011, 9'b101, 9'b111}, 8'b0000_0001, 1, 1, -1, 3,
                {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'b011, 3'b101, 3'b111}, 8'b0000_0110};

    rst = 1'b0; en = 1'b1; sel = 0;
    i_code_rate = 1'b0; i_constr_len = '0; i_gen_poly = '0;
    i_bit = 1'b0; i_bit_valid = 1'b0; i_sym_ready = 1'b0;
    repeat (3) @(negedge sys_clk);
    chk("reset bit_ready", obr, 1'b0);
    chk("reset sym_valid", osv, 1'b0);
    chk("reset code_sym", osym, 3'b000);
    chk("reset tail", otl, 1'b0);
    chk("reset frame_done", ofd, 1'b0);
    rst = 1'b1;
    @(negedge sys_clk);

    for (int v = 0; v < 4; v++) begin
      exp_sym.delete();
      exp_tail.delete();
      for (int i = 0; i < vecs[v].nexp; i++) begin
        exp_sym.push_back(vecs[v].exp_s[i]);
        exp_tail.push_back(vecs[v].exp_t[i]);
      end
      run_frame($sformatf("vec%0d", v), vecs[v].sel, vecs[v].rate, vecs[v].cl,
                vecs[v].poly, vecs[v].bits, vecs[v].nbits, vecs[v].rdy_mode,
                vecs[v].en_drop_at, got);
    end

    // K=9, eight data bits
    p = 27'($urandom());
    b = 8'($urandom());
    build_expect(1'b0, 2'd0, p, b, 8);
    run_frame("k9", 2, 1'b0, 2'd0, p, b, 8, 2, -1, k9_syms);
    chk("k9 total_syms", k9_syms, 16);

    // Abort a frame with reset after two data bits
    sel = 0; i_code_rate = 1'b1; i_constr_len = 2'd1;
    i_gen_poly = {9'h000, 9'b101, 9'b111};
    i_sym_ready = 1'b1;
    got = 0;
    for (int it = 0; it < 50 && got < 2; it++) begin
      @(negedge sys_clk);
      i_bit_valid = 1'b1;
      i_bit = 1'b1;
      #1;
      if (obr) got++;
    end
    chk("abort bits_sent", got, 2);
    @(negedge sys_clk);
    i_bit_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("abort sym_valid", osv, 1'b0);
    chk("abort code_sym", osym, 3'b000);
    chk("abort bit_ready", obr, 1'b0);
    chk("abort tail", otl, 1'b0);
    repeat (2) @(negedge sys_clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge sys_clk);
      chk("abort no_done", ofd, 1'b0);
    end
    p = 27'($urandom());
    b = 8'($urandom());
    build_expect(1'b0, 2'd2, p, b, 4);
    run_frame("post_abort", 0, 1'b0, 2'd2, p, b, 4, 0, -1, got);

    for (int f = 0; f < 10; f++) begin
      s = $urandom_range(0, 2);
      rate = 1'($urandom());
      cl = 2'($urandom());
      p = 27'($urandom());
      b = 8'($urandom());
      build_expect(rate, cl, p, b, fl[s]);
      run_frame($sformatf("rnd%0d", f), s, rate, cl, p, b, fl[s], 2,
                $urandom_range(0, exp_sym.size() - 1), got);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
